// File: rtl/sdf_pkg.sv
// Shared definitions for the single-path delay-feedback DIF stage:
// the feedback depth helper and the two-phase enum.
package sdf_pkg;

  // Phase of a slot inside one 2D block: first half fills, second half issues.
  typedef enum logic {
    PH_A = 1'b0,
    PH_B = 1'b1
  } phase_e;

  // Feedback depth D of a stage: N >> (STAGE+1), with N = 2**LOGN.
  function automatic int sdf_depth(input int logn, input int stage);
    return (1 << logn) >> (stage + 1);
  endfunction

endpackage

// File: rtl/sdf_delay_line.sv
// Enable-gated shift-register delay line. Shifts one place per enabled
// cycle; o_head is the element written DEPTH enabled cycles ago.
// Contents are not reset: the users track validity separately.
module sdf_delay_line #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic             i_clk,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Shift the line by one on every enabled cycle.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      r_mem[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_mem[i] <= r_mem[i-1];
      end
    end
  end

  assign o_head = r_mem[DEPTH-1];

endmodule

// File: rtl/sdf_dif_fb_ctrl.sv
// Single-path delay-feedback DIF NTT stage controller.
// Pairs element k with element k+D of each 2D block, issues them with a
// twiddle address to an external butterfly, and reorders the returned
// results into the stream: D a-results, then the D b-results of the
// same block (emitted during the next block's first half).
//
// Optional feature: define SDF_FB_FLUSH_EN to add a 'flush' input that
// injects zero-data slots while in_valid=0, draining the last b-results.
//
// Handshake: valid-only streams, no backpressure. in_valid qualifies
// in_data in the same cycle; btf_valid qualifies btf_a/btf_b; the
// butterfly results btf_out_a/btf_out_b are sampled on the BTF_LAT-th
// rising edge after the edge that raised btf_valid; out_valid qualifies
// out_data in the same cycle.
module sdf_dif_fb_ctrl
  import sdf_pkg::*;
#(
  parameter int LOGQ       = 64,
  parameter int LOGN       = 4,
  parameter int STAGE      = 0,
  parameter int BTF_LAT    = 6,
  parameter int DELAY_BROM = 2
) (
  input  logic            clk,
  input  logic            rst,
`ifdef SDF_FB_FLUSH_EN
  input  logic            flush,
`endif
  input  logic            in_valid,
  input  logic [LOGQ-1:0] in_data,
  output logic [LOGN-2:0] w_addr,
  output logic [LOGQ-1:0] btf_a,
  output logic [LOGQ-1:0] btf_b,
  output logic            btf_valid,
  input  logic [LOGQ-1:0] btf_out_a,
  input  logic [LOGQ-1:0] btf_out_b,
  output logic            out_valid,
  output logic [LOGQ-1:0] out_data
);

  localparam int D  = sdf_depth(LOGN, STAGE);
  localparam int CW = LOGN - STAGE;              // counts 0..2D-1
  localparam int IS = DELAY_BROM + 1;            // index of the butterfly issue stage
  localparam int PL = DELAY_BROM + BTF_LAT;      // index of the returning slot
  localparam logic [CW-1:0] D_C      = CW'(D);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * D - 1);

  logic [CW-1:0]   r_cnt;
  logic [LOGN-2:0] r_w_addr;
  logic            r_sv [1:PL];                  // slot valid, per cycle of travel
  phase_e          r_sp [1:PL];                  // slot phase, per cycle of travel
  logic [LOGQ-1:0] r_a  [1:IS];
  logic [LOGQ-1:0] r_b  [1:IS];
  logic            r_rv [D];                     // result-line entry holds a b-result
  logic            r_out_valid;
  logic [LOGQ-1:0] r_out_data;

  logic            w_slot;
  logic [LOGQ-1:0] w_slot_data;
  phase_e          w_phase;
  logic            w_issue;
  logic [LOGN-2:0] w_off;
  logic [LOGN-2:0] w_addr_nxt;
  logic [LOGQ-1:0] w_in_head;
  logic [LOGQ-1:0] w_res_head;
  logic [LOGQ-1:0] w_res_in;
  logic            w_ret_v;
  phase_e          w_ret_ph;

`ifdef SDF_FB_FLUSH_EN
  // A flush slot behaves like an accepted zero input; real input wins.
  assign w_slot      = in_valid | flush;
  assign w_slot_data = in_valid ? in_data : '0;
`else
  assign w_slot      = in_valid;
  assign w_slot_data = in_data;
`endif

  assign w_phase    = (r_cnt >= D_C) ? PH_B : PH_A;
  assign w_issue    = w_slot && (w_phase == PH_B);
  assign w_off      = (LOGN-1)'(r_cnt - D_C);
  assign w_addr_nxt = w_off << STAGE;

  // Input line: filled in phase A, its head is element cnt-D in phase B.
  sdf_delay_line #(
    .DEPTH (D),
    .WIDTH (LOGQ)
  ) u_in_line (
    .i_clk  (clk),
    .i_en   (w_slot),
    .i_data (w_slot_data),
    .o_head (w_in_head)
  );

  // Phase counter advances once per accepted slot and wraps at 2D-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_slot) begin
      r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CW'(1);
    end
  end

  // Twiddle address updates on phase-B slots and holds during phase A.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_w_addr <= '0;
    end else if (w_issue) begin
      r_w_addr <= w_addr_nxt;
    end
  end

  // Slot tracker: every accepted slot travels with its phase so the
  // returning results can be routed; it runs every cycle so gaps persist.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i <= PL; i++) begin
        r_sv[i] <= 1'b0;
        r_sp[i] <= PH_A;
      end
    end else begin
      r_sv[1] <= w_slot;
      r_sp[1] <= w_phase;
      for (int i = 2; i <= PL; i++) begin
        r_sv[i] <= r_sv[i-1];
        r_sp[i] <= r_sp[i-1];
      end
    end
  end

  // Operand pipeline: delays the butterfly pair to line up with ROM data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i <= IS; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
      end
    end else begin
      r_a[1] <= w_issue ? w_in_head   : '0;
      r_b[1] <= w_issue ? w_slot_data : '0;
      for (int i = 2; i <= IS; i++) begin
        r_a[i] <= r_a[i-1];
        r_b[i] <= r_b[i-1];
      end
    end
  end

  assign w_addr    = r_w_addr;
  assign btf_a     = r_a[IS];
  assign btf_b     = r_b[IS];
  assign btf_valid = r_sv[IS] && (r_sp[IS] == PH_B);

  assign w_ret_v  = r_sv[PL];
  assign w_ret_ph = r_sp[PL];
  assign w_res_in = (w_ret_ph == PH_B) ? btf_out_b : '0;

  // Result line: parks b-results until the next phase-A slots return.
  sdf_delay_line #(
    .DEPTH (D),
    .WIDTH (LOGQ)
  ) u_res_line (
    .i_clk  (clk),
    .i_en   (w_ret_v),
    .i_data (w_res_in),
    .o_head (w_res_head)
  );

  // Validity of each result-line entry, shifted alongside the data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < D; i++) begin
        r_rv[i] <= 1'b0;
      end
    end else if (w_ret_v) begin
      r_rv[0] <= (w_ret_ph == PH_B);
      for (int i = 1; i < D; i++) begin
        r_rv[i] <= r_rv[i-1];
      end
    end
  end

  // Output mux: a-results pass straight out, phase-A slots pop b-results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_ret_v) begin
      if (w_ret_ph == PH_B) begin
        r_out_valid <= 1'b1;
        r_out_data  <= btf_out_a;
      end else begin
        r_out_valid <= r_rv[D-1];
        r_out_data  <= r_rv[D-1] ? w_res_head : '0;
      end
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_sdf_dif_fb_ctrl.sv
// Bench for sdf_dif_fb_ctrl: a D=8 stage (LOGN=4, STAGE=0) and a D=1
// stage (STAGE=3), each with a modular add/sub butterfly model (q=7681).
module tb_sdf_dif_fb_ctrl;

  localparam int LOGQ = 64;
  localparam int LOGN = 4;
  localparam int DB   = 2;
  localparam int BL   = 6;
  localparam logic [63:0] Q = 64'd7681;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  w;
    logic [63:0] o;
  } vec_t;
  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  w;
  } btf_rec_t;
  typedef struct {
    logic [63:0] d;
    int          c;
  } out_rec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT 0: D=8 ----------------
  logic        in_valid0 = 1'b0;
  logic [63:0] in_data0  = '0;
  logic [2:0]  w_addr0;
  logic [63:0] btf_a0, btf_b0, bo_a0, bo_b0, out_data0;
  logic        btf_valid0, out_valid0;
`ifdef SDF_FB_FLUSH_EN
  logic        flush0 = 1'b0;
`endif

  sdf_dif_fb_ctrl #(
    .LOGQ(LOGQ), .LOGN(LOGN), .STAGE(0), .BTF_LAT(BL), .DELAY_BROM(DB)
  ) u_dut0 (
    .clk       (clk),
    .rst       (rst),
`ifdef SDF_FB_FLUSH_EN
    .flush     (flush0),
`endif
    .in_valid  (in_valid0),
    .in_data   (in_data0),
    .w_addr    (w_addr0),
    .btf_a     (btf_a0),
    .btf_b     (btf_b0),
    .btf_valid (btf_valid0),
    .btf_out_a (bo_a0),
    .btf_out_b (bo_b0),
    .out_valid (out_valid0),
    .out_data  (out_data0)
  );

  // ---------------- DUT 1: D=1 ----------------
  logic        in_valid1 = 1'b0;
  logic [63:0] in_data1  = '0;
  logic [2:0]  w_addr1;
  logic [63:0] btf_a1, btf_b1, bo_a1, bo_b1, out_data1;
  logic        btf_valid1, out_valid1;
`ifdef SDF_FB_FLUSH_EN
  logic        flush1 = 1'b0;
`endif

  sdf_dif_fb_ctrl #(
    .LOGQ(LOGQ), .LOGN(LOGN), .STAGE(3), .BTF_LAT(BL), .DELAY_BROM(DB)
  ) u_dut1 (
    .clk       (clk),
    .rst       (rst),
`ifdef SDF_FB_FLUSH_EN
    .flush     (flush1),
`endif
    .in_valid  (in_valid1),
    .in_data   (in_data1),
    .w_addr    (w_addr1),
    .btf_a     (btf_a1),
    .btf_b     (btf_b1),
    .btf_valid (btf_valid1),
    .btf_out_a (bo_a1),
    .btf_out_b (bo_b1),
    .out_valid (out_valid1),
    .out_data  (out_data1)
  );

  // ---------------- butterfly model ----------------
  function automatic logic [63:0] bf_add(input logic [63:0] a, input logic [63:0] b);
    return (a + b) % Q;
  endfunction
  function automatic logic [63:0] bf_sub(input logic [63:0] a, input logic [63:0] b);
    return (a + Q - b) % Q;
  endfunction

  // BL-1 registers here plus the DUT's sampling edge give BL cycles.
  logic [63:0] pa0 [BL-1], pb0 [BL-1], pa1 [BL-1], pb1 [BL-1];
  always @(posedge clk) begin
    pa0[0] <= bf_add(btf_a0, btf_b0);
    pb0[0] <= bf_sub(btf_a0, btf_b0);
    pa1[0] <= bf_add(btf_a1, btf_b1);
    pb1[0] <= bf_sub(btf_a1, btf_b1);
    for (int i = 1; i < BL - 1; i++) begin
      pa0[i] <= pa0[i-1];
      pb0[i] <= pb0[i-1];
      pa1[i] <= pa1[i-1];
      pb1[i] <= pb1[i-1];
    end
  end
  assign bo_a0 = pa0[BL-2];
  assign bo_b0 = pb0[BL-2];
  assign bo_a1 = pa1[BL-2];
  assign bo_b1 = pb1[BL-2];

  // ---------------- monitors ----------------
  btf_rec_t    btf_cap0[$], btf_cap1[$];
  out_rec_t    out_cap0[$], out_cap1[$];
  logic [2:0]  w_hist0 [DB], w_hist1 [DB];

  always @(negedge clk) begin
    w_hist0[0] <= w_addr0;
    w_hist1[0] <= w_addr1;
    for (int i = 1; i < DB; i++) begin
      w_hist0[i] <= w_hist0[i-1];
      w_hist1[i] <= w_hist1[i-1];
    end
    if (btf_valid0) btf_cap0.push_back('{btf_a0, btf_b0, w_hist0[DB-1]});
    if (btf_valid1) btf_cap1.push_back('{btf_a1, btf_b1, w_hist1[DB-1]});
    if (out_valid0) out_cap0.push_back('{out_data0, cyc});
    if (out_valid1) out_cap1.push_back('{out_data1, cyc});
  end

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int e0       = 0;
  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name);
    out_rec_t r;
    check({name, "_count"}, 64'(out_cap0.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && out_cap0.size() > 0) begin
      r = out_cap0.pop_front();
      check(name, r.d, exp_q.pop_front());
    end
  endtask

  task automatic clear_caps();
    btf_cap0.delete(); btf_cap1.delete();
    out_cap0.delete(); out_cap1.delete();
    exp_q.delete();
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    clear_caps();
  endtask

  task automatic drive0(input logic v, input logic [63:0] d);
    @(negedge clk);
    in_valid0 = v;
    in_data0  = d;
  endtask

  task automatic drive1(input logic v, input logic [63:0] d);
    @(negedge clk);
    in_valid1 = v;
    in_data1  = d;
  endtask

  task automatic ramp(input int base, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      drive0(1'b1, 64'(base + i));
      if (i == 0) e0 = cyc + 1;
      if (gap) drive0(1'b0, '0);
    end
    drive0(1'b0, '0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive0(1'b0, '0);
  endtask

  task automatic push_a_results();
    for (int i = 0; i < 8; i++) exp_q.push_back(tbl[i].o);
  endtask

  // ---------------- test ----------------
  initial begin
    out_rec_t r0, r1;
    tbl[0] = '{64'd0, 64'd8,  3'd0, 64'd8};
    tbl[1] = '{64'd1, 64'd9,  3'd1, 64'd10};
    tbl[2] = '{64'd2, 64'd10, 3'd2, 64'd12};
    tbl[3] = '{64'd3, 64'd11, 3'd3, 64'd14};
    tbl[4] = '{64'd4, 64'd12, 3'd4, 64'd16};
    tbl[5] = '{64'd5, 64'd13, 3'd5, 64'd18};
    tbl[6] = '{64'd6, 64'd14, 3'd6, 64'd20};
    tbl[7] = '{64'd7, 64'd15, 3'd7, 64'd22};

    // Reset state
    do_reset();
    check("rst_out_valid", 64'(out_valid0), 64'd0);
    check("rst_btf_valid", 64'(btf_valid0), 64'd0);
    check("rst_w_addr",    64'(w_addr0),    64'd0);
    check("rst_out_data",  out_data0,       64'd0);
    check("rst_btf_a",     btf_a0,          64'd0);
    check("rst_btf_b",     btf_b0,          64'd0);

    // Continuous ramp: butterfly pairs, twiddle addresses, latency, a-results only
    ramp(0, 16, 1'b0);
    idle(40);
    check("ramp_btf_count", 64'(btf_cap0.size()), 64'd8);
    for (int i = 0; i < 8 && i < btf_cap0.size(); i++) begin
      check("ramp_btf_a", btf_cap0[i].a, tbl[i].a);
      check("ramp_btf_b", btf_cap0[i].b, tbl[i].b);
      check("ramp_w_addr", 64'(btf_cap0[i].w), 64'(tbl[i].w));
    end
    if (out_cap0.size() > 0)
      check("ramp_latency", 64'(out_cap0[0].c - e0), 64'(8 + DB + BL));
    else
      check("ramp_latency_seen", 64'd0, 64'd1);
    push_a_results();
    check_outs("ramp_out");

    // Alternating in_valid: same data, alternating out_valid
    do_reset();
    ramp(0, 16, 1'b1);
    idle(40);
    for (int i = 1; i < out_cap0.size(); i++)
      check("gap_spacing", 64'(out_cap0[i].c - out_cap0[i-1].c), 64'd2);
    push_a_results();
    check_outs("gap_out");

    // Two back-to-back blocks: a1, b1, a2 with no gap
    do_reset();
    ramp(0, 32, 1'b0);
    idle(40);
    if (out_cap0.size() == 24) begin
      check("b2b_span", 64'(out_cap0[23].c - out_cap0[0].c), 64'd23);
      check("b2b_join", 64'(out_cap0[16].c - out_cap0[15].c), 64'd1);
    end else begin
      check("b2b_size", 64'(out_cap0.size()), 64'd24);
    end
    push_a_results();
    for (int i = 0; i < 8; i++) exp_q.push_back(64'd7673);
    for (int i = 0; i < 8; i++) exp_q.push_back(64'(40 + 2 * i));
    check_outs("b2b_out");

    // Reset at cnt=5 (asserted asynchronously), then a fresh block
    do_reset();
    ramp(99, 5, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_w_addr",   64'(w_addr0),    64'd0);
    check("mid_rst_out_data", out_data0,       64'd0);
    check("mid_rst_out_vld",  64'(out_valid0), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    clear_caps();
    ramp(0, 16, 1'b0);
    idle(40);
    push_a_results();
    check_outs("mid_rst_out");

    // Drain of the last block's b-results
    do_reset();
    ramp(0, 16, 1'b0);
`ifdef SDF_FB_FLUSH_EN
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid0 = 1'b0;
      flush0    = 1'b1;
    end
    @(negedge clk);
    flush0 = 1'b0;
    idle(40);
    push_a_results();
    for (int i = 0; i < 8; i++) exp_q.push_back(64'd7673);
    check_outs("flush_out");
`else
    idle(40);
    push_a_results();
    check_outs("noflush_out");
`endif

    // D=1 stage: phases alternate on every accepted input
    do_reset();
    drive1(1'b1, 64'd5);
    drive1(1'b1, 64'd9);
    drive1(1'b1, 64'd2);
    drive1(1'b1, 64'd3);
    drive1(1'b0, '0);
    repeat (30) drive1(1'b0, '0);
    check("d1_btf_count", 64'(btf_cap1.size()), 64'd2);
    if (btf_cap1.size() >= 2) begin
      check("d1_btf_a0", btf_cap1[0].a, 64'd5);
      check("d1_btf_b0", btf_cap1[0].b, 64'd9);
      check("d1_w_addr0", 64'(btf_cap1[0].w), 64'd0);
      check("d1_btf_a1", btf_cap1[1].a, 64'd2);
      check("d1_btf_b1", btf_cap1[1].b, 64'd3);
    end
    check("d1_out_count", 64'(out_cap1.size()), 64'd3);
    if (out_cap1.size() >= 3) begin
      r0 = out_cap1[0];
      r1 = out_cap1[1];
      check("d1_out0", r0.d, 64'd14);
      check("d1_out1", r1.d, 64'd7677);
      check("d1_out2", out_cap1[2].d, 64'd5);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
